// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro used by the top: PIPE_CTRL_PERF_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} hz_state_t;

  localparam logic [4:0] XZR              = 5'd31;
  localparam int         MAX_WAIT_DEFAULT = 12;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// Saturating wait-state counter with clear/increment and a sticky timeout flag.
module mem_wait_timer #(
  parameter int WAIT_CNT_W = 4,
  parameter int MAX_WAIT   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic err
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The flag latches on the same edge the counter lands on MAX_WAIT.
    err_d = err_q | (cnt_d == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, branch squash, memory wait).
// Define PIPE_CTRL_PERF_CNT_EN to add the stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int WAIT_CNT_W = 4,
  parameter int MAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events,
`endif
  output logic             mem_err
);

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(XZR);

  hz_state_t state_q, state_d;
  logic      load_use;
  logic      mem_stall;

  // A load-use seen in the bubble cycle is the same load, so it is masked there.
  assign load_use = ex_mem_read && (ex_rd != ZERO_REG) && (state_q != LOAD_STALL) &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (mem_stall) begin
      state_d = MEM_WAIT;
    end else if (!ex_branch_taken && load_use) begin
      state_d = LOAD_STALL;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  mem_wait_timer #(
    .WAIT_CNT_W (WAIT_CNT_W),
    .MAX_WAIT   (MAX_WAIT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!mem_stall),
    .inc (mem_stall),
    .err (mem_err)
  );

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (!mem_stall && ex_branch_taken && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a behavioural model.
// Honours PIPE_CTRL_PERF_CNT_EN when it is defined for the build.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checkCount = 0;
  int passCount  = 0;

  // Model state: was the previous cycle a load-use bubble, how many
  // consecutive memory-stall cycles so far, and the sticky timeout flag.
  bit    mPrevLoadStall = 0;
  int    mStallRun      = 0;
  bit    mErr           = 0;
  longint mStallCycles  = 0;
  longint mFlushEvents  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
`endif
    .mem_err         (mem_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      passCount++;
    end
  endtask

  // Drive one cycle of inputs, check the outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input string tag, input bit r,
                               input int rn, input bit urn, input int rm, input bit urm,
                               input int rd, input bit mrd, input bit br,
                               input bit mq, input bit my);
    bit         lu, ms;
    logic [4:0] en;
    logic [2:0] fl;
    @(negedge clk);
    rst = r; id_rn = 5'(rn); id_rm = 5'(rm); id_uses_rn = urn; id_uses_rm = urm;
    ex_rd = 5'(rd); ex_mem_read = mrd; ex_branch_taken = br; mem_req = mq; mem_ready = my;
    #1;
    lu = mrd && (rd != 31) && ((urn && rn == rd) || (urm && rm == rd)) && !mPrevLoadStall;
    ms = mq && !my;
    if (!r)      begin en = 5'b00000; fl = 3'b111; end
    else if (ms) begin en = 5'b00001; fl = 3'b001; end
    else if (br) begin en = 5'b11111; fl = 3'b110; end
    else if (lu) begin en = 5'b00111; fl = 3'b010; end
    else         begin en = 5'b11111; fl = 3'b000; end
    checkOutput(tag,
                32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, mem_wb_flush, mem_err}),
                32'({en, fl, mErr}));
`ifdef PIPE_CTRL_PERF_CNT_EN
    checkOutput({tag, ".stall_cycles"}, stall_cycles, 32'(mStallCycles));
    checkOutput({tag, ".flush_events"}, flush_events, 32'(mFlushEvents));
`endif
    @(posedge clk);
    if (!r) begin
      mPrevLoadStall = 0; mStallRun = 0; mErr = 0; mStallCycles = 0; mFlushEvents = 0;
    end else begin
      mPrevLoadStall = !ms && !br && lu;
      if (ms) begin
        if (mStallRun < 12) mStallRun++;
        if (mStallRun == 12) mErr = 1;
      end else begin
        mStallRun = 0;
      end
      if (!en[4] && mStallCycles < 64'hFFFF_FFFF) mStallCycles++;
      if (!ms && br && mFlushEvents < 64'hFFFF_FFFF) mFlushEvents++;
    end
  endtask

  function automatic int pickReg();
    int v = int'($urandom_range(0, 4));
    return (v == 4) ? 31 : v;
  endfunction

  initial begin
    int burst = 0;
    rst = 1'b0; id_rn = '0; id_rm = '0; id_uses_rn = 0; id_uses_rm = 0;
    ex_rd = '0; ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;

    applyStimulus("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("loaduse_stall",  1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    applyStimulus("loaduse_masked", 1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    applyStimulus("loaduse_after",  1, 3, 1, 0, 0, 5, 0, 0, 0, 0);

    applyStimulus("xzr_exempt", 1, 31, 1, 31, 1, 31, 1, 0, 0, 0);

    applyStimulus("branch_vs_lu", 1, 3, 1, 0, 0, 3, 1, 1, 0, 0);
    applyStimulus("branch_next",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) applyStimulus("memwait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("memwait_ready", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("memwait_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) applyStimulus("timeout", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("timeout_ready", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("timeout_sticky", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("timeout_sticky2", 1, 2, 1, 0, 0, 2, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++) applyStimulus("midwait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("midwait_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("post_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, mq, my;
      if (burst == 0 && $urandom_range(0, 24) == 0) burst = int'($urandom_range(1, 16));
      if (burst > 0) begin
        mq = 1; my = 0; burst--;
      end else begin
        mq = 1'($urandom_range(0, 1)); my = ($urandom_range(0, 3) != 0);
      end
      r = ($urandom_range(0, 99) != 0);
      applyStimulus("random", r, pickReg(), 1'($urandom), pickReg(), 1'($urandom),
                    pickReg(), ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0), mq, my);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
